// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for pipe_skid_stage: upstream (in_*) and downstream (out_*) sides.
// The stage uses the slave view; the producer/consumer environment uses the master view.
interface pipe_skid_stage_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage register with optional skid entry, synchronous flush,
// occupancy report and saturating stall-cycle counter.
module pipe_skid_stage #(
  parameter int unsigned      WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit               SKID   = 1'b1,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              flush,
  pipe_skid_stage_if.slave  bus,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q,  main_d;
  logic [WIDTH-1:0]   skid_q,  skid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic main_v, skid_v, in_ready, in_xfer, out_xfer;

  assign main_v = (state_q != ST_EMPTY);
  assign skid_v = (state_q == ST_SKID);

  // With a skid entry, in_ready decodes from state only, so no path from out_ready.
  assign in_ready = SKID ? ~skid_v : (~main_v | bus.out_ready);
  assign in_xfer  = bus.in_valid & in_ready;
  assign out_xfer = main_v & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_v;
  assign bus.out_data  = main_q;
  assign occupancy     = {1'b0, main_v} + {1'b0, skid_v};
  assign stall_cycles  = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if (main_v && !bus.out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d = ST_FULL;
          main_d  = bus.in_data;
        end
      end
      ST_FULL: begin
        if (in_xfer && out_xfer) begin
          main_d = bus.in_data;
        end else if (in_xfer) begin
          // Only reachable with SKID=1; single-entry in_ready implies out_ready when full.
          state_d = ST_SKID;
          skid_d  = bus.in_data;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_xfer) begin
          state_d = ST_FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a skid instance (CNT_W=4) and a single-entry instance,
// checked every cycle against a queue model, plus directed literal scenarios.
module tb_pipe_skid_stage;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RESET;
  logic       fl   [2];
  logic       iv   [2];
  logic [7:0] id   [2];
  logic       ordy [2];

  pipe_skid_stage_if #(.WIDTH(W)) bus0 ();
  pipe_skid_stage_if #(.WIDTH(W)) bus1 ();

  assign bus0.in_valid  = iv[0];
  assign bus0.in_data   = id[0];
  assign bus0.out_ready = ordy[0];
  assign bus1.in_valid  = iv[1];
  assign bus1.in_data   = id[1];
  assign bus1.out_ready = ordy[1];

  logic [1:0]  occ0, occ1;
  logic [3:0]  st0;
  logic [15:0] st1;

  pipe_skid_stage #(.WIDTH(W), .BUBBLE(8'hB5), .SKID(1'b1), .CNT_W(4)) dut0 (
    .clk(clk), .RESET(RESET), .flush(fl[0]), .bus(bus0),
    .occupancy(occ0), .stall_cycles(st0)
  );

  pipe_skid_stage #(.WIDTH(W), .BUBBLE(8'h3C), .SKID(1'b0), .CNT_W(16)) dut1 (
    .clk(clk), .RESET(RESET), .flush(fl[1]), .bus(bus1),
    .occupancy(occ1), .stall_cycles(st1)
  );

  logic        a_ir  [2];
  logic        a_ov  [2];
  logic [7:0]  a_od  [2];
  logic [1:0]  a_occ [2];
  logic [15:0] a_st  [2];
  assign a_ir[0]  = bus0.in_ready;   assign a_ir[1]  = bus1.in_ready;
  assign a_ov[0]  = bus0.out_valid;  assign a_ov[1]  = bus1.out_valid;
  assign a_od[0]  = bus0.out_data;   assign a_od[1]  = bus1.out_data;
  assign a_occ[0] = occ0;            assign a_occ[1] = occ1;
  assign a_st[0]  = {12'b0, st0};    assign a_st[1]  = st1;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance a FIFO of at most 2 entries plus the shown head value.
  function automatic logic [7:0] bub(input int d);
    return (d == 0) ? 8'hB5 : 8'h3C;
  endfunction
  function automatic int unsigned smax(input int d);
    return (d == 0) ? 15 : 65535;
  endfunction
  function automatic bit has_skid(input int d);
    return d == 0;
  endfunction

  int          mcnt  [2];
  logic [7:0]  mq    [2][2];
  logic [7:0]  mhead [2];
  int unsigned mst   [2];

  function automatic bit m_ready(input int d);
    return has_skid(d) ? (mcnt[d] < 2) : (mcnt[d] == 0 || ordy[d]);
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0; mhead[d] = bub(d); mst[d] = 0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        bit ov, ir;
        ov = mcnt[d] > 0;
        ir = m_ready(d);
        if (RESET) begin
          mcnt[d] = 0; mhead[d] = bub(d); mst[d] = 0;
        end else begin
          if (ov && !ordy[d] && mst[d] < smax(d)) mst[d]++;
          if (fl[d]) begin
            mcnt[d] = 0; mhead[d] = bub(d);
          end else begin
            if (ov && ordy[d]) begin
              mq[d][0] = mq[d][1];
              mcnt[d]--;
            end
            if (iv[d] && ir) begin
              mq[d][mcnt[d]] = id[d];
              mcnt[d]++;
            end
            if (mcnt[d] > 0) mhead[d] = mq[d][0];
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int d = 0; d < 2; d++) begin
          chk("in_ready",     d, {31'b0, a_ir[d]},  {31'b0, m_ready(d)});
          chk("out_valid",    d, {31'b0, a_ov[d]},  {31'b0, mcnt[d] > 0});
          chk("out_data",     d, {24'b0, a_od[d]},  {24'b0, mhead[d]});
          chk("occupancy",    d, {30'b0, a_occ[d]}, mcnt[d]);
          chk("stall_cycles", d, {16'b0, a_st[d]},  mst[d]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    for (int d = 0; d < 2; d++) begin
      fl[d] = 1'b0; iv[d] = 1'b0; id[d] = 8'h00; ordy[d] = 1'b0;
    end
    tick(); tick();
    cmp_en = 1'b1;
    chk("rst_out_valid", 0, {31'b0, a_ov[0]}, 0);
    chk("rst_out_data",  0, {24'b0, a_od[0]}, 32'hB5);
    chk("rst_occ",       0, {30'b0, a_occ[0]}, 0);
    chk("rst_stall",     0, {16'b0, a_st[0]}, 0);
    chk("rst_in_ready",  0, {31'b0, a_ir[0]}, 1);
    chk("rst_in_ready",  1, {31'b0, a_ir[1]}, 1);
    chk("rst_out_data",  1, {24'b0, a_od[1]}, 32'h3C);
    RESET = 1'b0;

    // Stream 1..4 with out_ready high
    ordy[0] = 1'b1; iv[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      id[0] = 8'(k);
      tick();
      chk("stream_data", 0, {24'b0, a_od[0]}, k);
      chk("stream_occ",  0, {30'b0, a_occ[0]}, 1);
    end
    iv[0] = 1'b0;
    tick();
    chk("stream_stall", 0, {16'b0, a_st[0]}, 0);

    // Skid absorb: A, then B/C while out_ready is low for 3 cycles
    iv[0] = 1'b1; id[0] = 8'h0A; ordy[0] = 1'b1;
    tick();
    chk("skid_head", 0, {24'b0, a_od[0]}, 32'h0A);
    id[0] = 8'h0B; ordy[0] = 1'b0;
    tick();
    chk("skid_occ2",  0, {30'b0, a_occ[0]}, 2);
    chk("skid_irdy0", 0, {31'b0, a_ir[0]}, 0);
    id[0] = 8'h0C;
    tick(); tick();
    chk("skid_stall3", 0, {16'b0, a_st[0]}, 3);
    chk("skid_hold_a", 0, {24'b0, a_od[0]}, 32'h0A);
    ordy[0] = 1'b1;
    tick();
    chk("skid_out_b", 0, {24'b0, a_od[0]}, 32'h0B);
    tick();
    chk("skid_out_c", 0, {24'b0, a_od[0]}, 32'h0C);
    iv[0] = 1'b0;
    tick();
    chk("drain_valid", 0, {31'b0, a_ov[0]}, 0);
    chk("drain_hold",  0, {24'b0, a_od[0]}, 32'h0C);

    // Flush while holding two entries, with a discarded 0x55 offered
    ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 8'h01;
    tick();
    id[0] = 8'h02;
    tick();
    chk("fl_occ2", 0, {30'b0, a_occ[0]}, 2);
    fl[0] = 1'b1; id[0] = 8'h55;
    tick();
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("fl_valid", 0, {31'b0, a_ov[0]}, 0);
    chk("fl_data",  0, {24'b0, a_od[0]}, 32'hB5);
    chk("fl_occ",   0, {30'b0, a_occ[0]}, 0);
    chk("fl_irdy",  0, {31'b0, a_ir[0]}, 1);
    chk("fl_stall", 0, {16'b0, a_st[0]}, 5);
    ordy[0] = 1'b1;
    tick();
    chk("fl_no55", 0, {31'b0, a_ov[0]}, 0);

    // Saturation, flush keeps count, then reset from SKID state
    ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 8'h07;
    repeat (20) tick();
    chk("sat15", 0, {16'b0, a_st[0]}, 15);
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    chk("sat_after_flush", 0, {16'b0, a_st[0]}, 15);
    id[0] = 8'h08;
    tick();
    id[0] = 8'h09;
    tick();
    chk("pre_rst_occ", 0, {30'b0, a_occ[0]}, 2);
    RESET = 1'b1;
    tick();
    RESET = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b1;
    chk("mid_rst_valid", 0, {31'b0, a_ov[0]}, 0);
    chk("mid_rst_data",  0, {24'b0, a_od[0]}, 32'hB5);
    chk("mid_rst_occ",   0, {30'b0, a_occ[0]}, 0);
    chk("mid_rst_stall", 0, {16'b0, a_st[0]}, 0);
    chk("mid_rst_irdy",  0, {31'b0, a_ir[0]}, 1);
    repeat (3) tick();
    chk("mid_rst_gone", 0, {31'b0, a_ov[0]}, 0);

    // Single-entry mode: combinational in_ready
    iv[1] = 1'b1; id[1] = 8'h11; ordy[1] = 1'b0;
    tick();
    id[1] = 8'h22;
    chk("s0_full_irdy0", 1, {31'b0, a_ir[1]}, 0);
    chk("s0_head",       1, {24'b0, a_od[1]}, 32'h11);
    ordy[1] = 1'b1;
    #1;
    chk("s0_irdy_comb", 1, {31'b0, a_ir[1]}, 1);
    tick();
    chk("s0_replace", 1, {24'b0, a_od[1]}, 32'h22);
    chk("s0_occ",     1, {30'b0, a_occ[1]}, 1);
    iv[1] = 1'b0;
    tick();

    // Randomised traffic on both instances
    for (int c = 0; c < 4000; c++) begin
      RESET = ($urandom_range(0, 599) == 0);
      for (int d = 0; d < 2; d++) begin
        fl[d]   = ($urandom_range(0, 31) == 0);
        iv[d]   = ($urandom_range(0, 3) != 0);
        id[d]   = 8'($urandom);
        ordy[d] = (c % 200 < 40) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      end
      tick();
    end
    RESET = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
